d_sync_debounce: RTL



---
 rtl/d_sync_debounce_pkg.sv | 19 +
 rtl/d_sync_debounce_sync_chain.sv | 33 +++
 rtl/d_sync_debounce.sv | 93 +++++++++
 3 files changed

// File: rtl/d_sync_debounce_pkg.sv
// ---------------------------------------------------------------------------
// d_sync_debounce_pkg
// Shared definitions for the D-input conditioning stage:
//   - db_state_e : debounce filter state (LOW/HIGH). The state value is the
//                  debounced level itself.
//   - *_DEF      : default parameter values, reused by the top and the bench.
// ---------------------------------------------------------------------------
package d_sync_debounce_pkg;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } db_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 4;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/d_sync_debounce_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Plain flop chain that brings an asynchronous single-bit input into the clk
// domain. Reusable for any async input in the lab.
// Ports:
//   clk   : clock, all updates on posedge
//   rst_n : synchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : last stage of the chain
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // No logic between stages, so each flop gets a full cycle to resolve.
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/d_sync_debounce.sv
// ---------------------------------------------------------------------------
// d_sync_debounce
// Conditions a raw, asynchronous, possibly bouncing data input into the clean
// D level that feeds the downstream latch/flop stages.
//   d_in -> sync_chain -> consecutive-cycle debounce filter -> q_db
//   q_db -> edge detection (rise/fall) -> wrapping rising-edge counter
// Ports:
//   clk      : clock, all updates on posedge
//   rst_n    : synchronous active-low reset, dominates everything
//   d_in     : raw asynchronous input
//   cnt_clr  : synchronous clear of edge_cnt (wins over increment)
//   q_sync   : synchronized, undebounced input
//   q_db     : debounced level
//   rise     : one-cycle pulse in the cycle after q_db goes 0->1
//   fall     : one-cycle pulse in the cycle after q_db goes 1->0
//   edge_cnt : number of rise pulses, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module d_sync_debounce
  import d_sync_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             cnt_clr,
  output logic             q_sync,
  output logic             q_db,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int            DB_W     = $clog2(DB_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  db_state_e       state;
  logic [DB_W-1:0] db_cnt;
  logic            q_db_d;

  // Synchronizer stage
  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d_in),
    .q     (q_sync)
  );

  // Debounce stage: q_db only follows q_sync after DB_CYCLES consecutive
  // disagreeing samples; any agreement in between restarts the count, so a
  // shorter glitch leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LOW;
      db_cnt <= '0;
    end else if (q_sync != state) begin
      if (db_cnt == DB_LAST) begin
        state  <= db_state_e'(q_sync);
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign q_db = (state == HIGH);

  // Edge detection / event counter stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_db_d   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      q_db_d <= q_db;
      if (cnt_clr) begin
        edge_cnt <= '0;
      end else if (rise) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // q_db and q_db_d reset together, so leaving reset never fakes an edge.
  assign rise = q_db & ~q_db_d;
  assign fall = ~q_db & q_db_d;

endmodule
